// File: rtl/dma_transfer_engine.sv
// rtl/dma_transfer_engine.sv - DMA engine: device request/ack responder driving the openMSP430 DMA master port
//
// Moves a block of 16-bit words between a requesting device and memory.
// The device presents start address, word count and direction with a level
// request. Each word is handshaked with dev_ack, carried out as one memory
// access and acknowledged with a one-cycle dma_ack. Completion or failure is
// then reported as a level flag until the request drops.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   dma_rqst            device block request (level)
//   dma_rd_wr           1 = memory->device, 0 = device->memory
//   dma_start_address   first byte address (bit 0 ignored)
//   dma_num_words       number of words to move
//   dev_ack             device ready for the next word
//   dev_out             write data from the device
//   dev_in              registered read data to the device
//   dma_ack             one-cycle pulse per completed word
//   dma_end_flag        transfer finished (level)
//   dma_error_flag      transfer failed (level)
//   dma_addr/din/en/we  memory master request
//   dma_priority        constant bus priority
//   dma_dout/ready/resp memory master response

module dma_transfer_engine #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic        DMA_PRIO       = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dma_rqst,
    input  logic        dma_rd_wr,
    input  logic [15:0] dma_start_address,
    input  logic [15:0] dma_num_words,
    input  logic        dev_ack,
    input  logic [15:0] dev_out,
    output logic [15:0] dev_in,
    output logic        dma_ack,
    output logic        dma_end_flag,
    output logic        dma_error_flag,
    output logic [14:0] dma_addr,
    output logic [15:0] dma_din,
    output logic        dma_en,
    output logic [1:0]  dma_we,
    output logic        dma_priority,
    input  logic [15:0] dma_dout,
    input  logic        dma_ready,
    input  logic        dma_resp
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_DEV = 3'd1,
        ACCESS   = 3'd2,
        ACK      = 3'd3,
        GAP      = 3'd4,
        DONE     = 3'd5,
        ERR      = 3'd6
    } state_t;

    // The error fires when the incremented wait count would reach
    // TIMEOUT_CYCLES, so dma_en stays high for exactly TIMEOUT_CYCLES cycles.
    localparam bit         TO_ENABLE = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    // Word address: a byte address stepping by 2 modulo 2^16 is the same as
    // a word address stepping by 1 modulo 2^15.
    logic [14:0] addr, addr_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic        dir, dir_nxt;
    logic [7:0]  tcnt, tcnt_nxt;
    logic [15:0] dev_in_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            addr   <= 15'd0;
            cnt    <= 16'd0;
            dir    <= 1'b0;
            tcnt   <= 8'd0;
            dev_in <= 16'd0;
        end else begin
            state  <= state_nxt;
            addr   <= addr_nxt;
            cnt    <= cnt_nxt;
            dir    <= dir_nxt;
            tcnt   <= tcnt_nxt;
            dev_in <= dev_in_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        addr_nxt   = addr;
        cnt_nxt    = cnt;
        dir_nxt    = dir;
        tcnt_nxt   = tcnt;
        dev_in_nxt = dev_in;

        case (state)
            IDLE: begin
                tcnt_nxt = 8'd0;
                if (dma_rqst) begin
                    addr_nxt = 15'((dma_start_address & 16'hFFFE) >> 1);
                    cnt_nxt  = dma_num_words;
                    dir_nxt  = dma_rd_wr;
                    state_nxt = (dma_num_words == 16'd0) ? DONE : WAIT_DEV;
                end
            end

            WAIT_DEV: begin
                if (!dma_rqst) begin
                    state_nxt = IDLE;
                end else if (dev_ack) begin
                    tcnt_nxt  = 8'd0;
                    state_nxt = ACCESS;
                end
            end

            ACCESS: begin
                if (dma_ready) begin
                    if (dma_resp) begin
                        state_nxt = ERR;
                    end else begin
                        if (dir) begin
                            dev_in_nxt = dma_dout;
                        end
                        addr_nxt = addr + 15'd1;
                        cnt_nxt  = cnt - 16'd1;
                        // A dropped request still lets the access finish,
                        // but the word is not acknowledged.
                        state_nxt = dma_rqst ? ACK : IDLE;
                    end
                end else begin
                    tcnt_nxt = tcnt + 8'd1;
                    if (TO_ENABLE && (tcnt == TO_LAST)) begin
                        state_nxt = ERR;
                    end
                end
            end

            ACK: begin
                state_nxt = GAP;
            end

            // dev_ack is ignored here so a device that holds it for an
            // extra cycle does not trigger a second word.
            GAP: begin
                if (cnt == 16'd0) begin
                    state_nxt = DONE;
                end else if (!dma_rqst) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = WAIT_DEV;
                end
            end

            DONE, ERR: begin
                if (!dma_rqst) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decode from the state register so that an asynchronous reset
    // returns them to their idle values immediately.
    always_comb begin
        dma_en         = 1'b0;
        dma_addr       = 15'd0;
        dma_we         = 2'b00;
        dma_din        = 16'd0;
        dma_ack        = 1'b0;
        dma_end_flag   = 1'b0;
        dma_error_flag = 1'b0;

        case (state)
            ACCESS: begin
                dma_en   = 1'b1;
                dma_addr = addr;
                dma_we   = dir ? 2'b00 : 2'b11;
                dma_din  = dev_out;
            end
            ACK: begin
                dma_ack = 1'b1;
            end
            DONE: begin
                dma_end_flag = 1'b1;
            end
            ERR: begin
                dma_end_flag   = 1'b1;
                dma_error_flag = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign dma_priority = DMA_PRIO;

endmodule

// File: tb/tb_dma_transfer_engine.sv
// tb/tb_dma_transfer_engine.sv - directed self-checking bench for dma_transfer_engine

module tb_dma_transfer_engine;

    logic        clk;
    logic        reset_n;
    logic        dma_rqst;
    logic        dma_rd_wr;
    logic [15:0] dma_start_address;
    logic [15:0] dma_num_words;
    logic        dev_ack;
    logic [15:0] dev_out;
    logic [15:0] dev_in;
    logic        dma_ack;
    logic        dma_end_flag;
    logic        dma_error_flag;
    logic [14:0] dma_addr;
    logic [15:0] dma_din;
    logic        dma_en;
    logic [1:0]  dma_we;
    logic        dma_priority;
    logic [15:0] dma_dout;
    logic        dma_ready;
    logic        dma_resp;

    logic        ready_en;
    logic        resp_force;
    logic [15:0] mem [0:255];

    int checks;
    int errors;

    dma_transfer_engine #(
        .TIMEOUT_CYCLES(4),
        .DMA_PRIO(1'b0)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .dma_rqst(dma_rqst),
        .dma_rd_wr(dma_rd_wr),
        .dma_start_address(dma_start_address),
        .dma_num_words(dma_num_words),
        .dev_ack(dev_ack),
        .dev_out(dev_out),
        .dev_in(dev_in),
        .dma_ack(dma_ack),
        .dma_end_flag(dma_end_flag),
        .dma_error_flag(dma_error_flag),
        .dma_addr(dma_addr),
        .dma_din(dma_din),
        .dma_en(dma_en),
        .dma_we(dma_we),
        .dma_priority(dma_priority),
        .dma_dout(dma_dout),
        .dma_ready(dma_ready),
        .dma_resp(dma_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait memory model; ready_en low stalls, resp_force answers with an error.
    assign dma_ready = dma_en & ready_en;
    assign dma_resp  = dma_en & resp_force;
    assign dma_dout  = mem[dma_addr[7:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        mem[2] = 16'h3333;

        reset_n           = 1'b0;
        dma_rqst          = 1'b0;
        dma_rd_wr         = 1'b0;
        dma_start_address = 16'h0000;
        dma_num_words     = 16'h0000;
        dev_ack           = 1'b0;
        dev_out           = 16'h0000;
        ready_en          = 1'b1;
        resp_force        = 1'b0;

        // Reset state
        cyc(2);
        chk("rst_en", 32'(dma_en), 32'h0);
        chk("rst_ack", 32'(dma_ack), 32'h0);
        chk("rst_end", 32'(dma_end_flag), 32'h0);
        chk("rst_err", 32'(dma_error_flag), 32'h0);
        chk("rst_dev_in", 32'(dev_in), 32'h0);
        chk("rst_addr", 32'(dma_addr), 32'h0);
        chk("rst_we", 32'(dma_we), 32'h0);
        chk("rst_prio", 32'(dma_priority), 32'h0);
        reset_n = 1'b1;
        cyc(1);

        // Read 3 words from 0x0200
        dma_start_address = 16'h0200;
        dma_num_words     = 16'd3;
        dma_rd_wr         = 1'b1;
        dev_ack           = 1'b1;
        dma_rqst          = 1'b1;
        for (int w = 0; w < 3; w++) begin
            cyc(1);
            chk("rd_wait_en", 32'(dma_en), 32'h0);
            cyc(1);
            chk("rd_en", 32'(dma_en), 32'h1);
            chk("rd_addr", 32'(dma_addr), 32'h100 + 32'(w));
            chk("rd_we", 32'(dma_we), 32'h0);
            cyc(1);
            chk("rd_ack", 32'(dma_ack), 32'h1);
            chk("rd_en_drop", 32'(dma_en), 32'h0);
            chk("rd_dev_in", 32'(dev_in), 32'h1111 * (32'(w) + 32'h1));
            cyc(1);
            chk("rd_gap_ack", 32'(dma_ack), 32'h0);
            chk("rd_gap_end", 32'(dma_end_flag), 32'h0);
        end
        cyc(1);
        chk("rd_end", 32'(dma_end_flag), 32'h1);
        chk("rd_err", 32'(dma_error_flag), 32'h0);
        cyc(1);
        chk("rd_end_hold", 32'(dma_end_flag), 32'h1);
        dma_rqst = 1'b0;
        cyc(1);
        chk("rd_end_clr", 32'(dma_end_flag), 32'h0);

        // Write 2 words to 0x0301 with dev_ack pulsed per word
        dma_start_address = 16'h0301;
        dma_num_words     = 16'd2;
        dma_rd_wr         = 1'b0;
        dev_ack           = 1'b0;
        dev_out           = 16'hABCD;
        dma_rqst          = 1'b1;
        cyc(2);
        chk("wr_wait_en", 32'(dma_en), 32'h0);
        dev_ack = 1'b1;
        cyc(1);
        dev_ack = 1'b0;
        #1;
        chk("wr0_en", 32'(dma_en), 32'h1);
        chk("wr0_we", 32'(dma_we), 32'h3);
        chk("wr0_addr", 32'(dma_addr), 32'h180);
        chk("wr0_din", 32'(dma_din), 32'hABCD);
        cyc(1);
        chk("wr0_ack", 32'(dma_ack), 32'h1);
        chk("wr0_din_idle", 32'(dma_din), 32'h0);
        cyc(2);
        dev_out = 16'h1234;
        dev_ack = 1'b1;
        cyc(1);
        dev_ack = 1'b0;
        #1;
        chk("wr1_en", 32'(dma_en), 32'h1);
        chk("wr1_we", 32'(dma_we), 32'h3);
        chk("wr1_addr", 32'(dma_addr), 32'h181);
        chk("wr1_din", 32'(dma_din), 32'h1234);
        cyc(1);
        chk("wr1_ack", 32'(dma_ack), 32'h1);
        cyc(2);
        chk("wr_end", 32'(dma_end_flag), 32'h1);
        chk("wr_err", 32'(dma_error_flag), 32'h0);
        chk("wr_dev_in_kept", 32'(dev_in), 32'h3333);
        dma_rqst = 1'b0;
        cyc(1);

        // Zero-length request
        dma_num_words = 16'd0;
        dma_rd_wr     = 1'b1;
        dev_ack       = 1'b1;
        dma_rqst      = 1'b1;
        cyc(1);
        chk("zero_en0", 32'(dma_en), 32'h0);
        chk("zero_end", 32'(dma_end_flag), 32'h1);
        cyc(1);
        chk("zero_en1", 32'(dma_en), 32'h0);
        dma_rqst = 1'b0;
        cyc(1);
        chk("zero_end_clr", 32'(dma_end_flag), 32'h0);

        // Error response on the second access
        dma_start_address = 16'h0200;
        dma_num_words     = 16'd3;
        dma_rd_wr         = 1'b1;
        dev_ack           = 1'b1;
        dma_rqst          = 1'b1;
        cyc(3);
        chk("er_ack1", 32'(dma_ack), 32'h1);
        chk("er_dev_in1", 32'(dev_in), 32'h1111);
        cyc(1);
        resp_force = 1'b1;
        cyc(2);
        chk("er_en2", 32'(dma_en), 32'h1);
        cyc(1);
        chk("er_no_ack", 32'(dma_ack), 32'h0);
        chk("er_err", 32'(dma_error_flag), 32'h1);
        chk("er_end", 32'(dma_end_flag), 32'h1);
        chk("er_en_drop", 32'(dma_en), 32'h0);
        chk("er_dev_in_kept", 32'(dev_in), 32'h1111);
        resp_force = 1'b0;
        dma_rqst   = 1'b0;
        cyc(1);
        chk("er_err_clr", 32'(dma_error_flag), 32'h0);
        chk("er_end_clr", 32'(dma_end_flag), 32'h0);

        // Timeout with dma_ready held low
        ready_en      = 1'b0;
        dma_num_words = 16'd1;
        dma_rqst      = 1'b1;
        cyc(1);
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            chk("to_en", 32'(dma_en), 32'h1);
            chk("to_err_low", 32'(dma_error_flag), 32'h0);
        end
        cyc(1);
        chk("to_en_drop", 32'(dma_en), 32'h0);
        chk("to_err", 32'(dma_error_flag), 32'h1);
        chk("to_end", 32'(dma_end_flag), 32'h1);
        dma_rqst = 1'b0;
        ready_en = 1'b1;
        cyc(1);
        chk("to_err_clr", 32'(dma_error_flag), 32'h0);

        // Request dropped in WAIT_DEV at word 2 of 5
        dma_num_words = 16'd5;
        dma_rqst      = 1'b1;
        cyc(3);
        chk("ab_ack1", 32'(dma_ack), 32'h1);
        cyc(2);
        chk("ab_wait_en", 32'(dma_en), 32'h0);
        dma_rqst = 1'b0;
        cyc(1);
        chk("ab_en", 32'(dma_en), 32'h0);
        chk("ab_end", 32'(dma_end_flag), 32'h0);
        chk("ab_err", 32'(dma_error_flag), 32'h0);
        cyc(1);
        chk("ab_en_idle", 32'(dma_en), 32'h0);

        // Reset pulsed during a stalled ACCESS
        ready_en      = 1'b0;
        dma_num_words = 16'd2;
        dma_rqst      = 1'b1;
        cyc(2);
        chk("rs_en_pre", 32'(dma_en), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rs_en", 32'(dma_en), 32'h0);
        chk("rs_addr", 32'(dma_addr), 32'h0);
        chk("rs_we", 32'(dma_we), 32'h0);
        chk("rs_din", 32'(dma_din), 32'h0);
        chk("rs_dev_in", 32'(dev_in), 32'h0);
        chk("rs_ack", 32'(dma_ack), 32'h0);
        chk("rs_end", 32'(dma_end_flag), 32'h0);
        chk("rs_err", 32'(dma_error_flag), 32'h0);
        chk("rs_prio", 32'(dma_priority), 32'h0);
        dma_rqst = 1'b0;
        ready_en = 1'b1;
        cyc(1);
        reset_n = 1'b1;
        cyc(2);
        chk("rs_idle_en", 32'(dma_en), 32'h0);
        chk("rs_idle_end", 32'(dma_end_flag), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_transfer_engine.md
Name: dma_transfer_engine

Overview:
- DMA controller engine: the responder side of the device-to-DMA request/acknowledge protocol used by the DMA peripheral.
- Accepts a block request (start address, word count, direction) from a device and moves 16-bit words between that device and memory over the openMSP430 DMA master port.
- Acknowledges each word, then reports completion or error back to the device.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles dma_en may wait for dma_ready before the transfer is flagged as an error (8-bit counter; 0 disables the timeout)
DMA_PRIO, 0, constant value driven on dma_priority

Ports:
clk  in  1  main system clock
reset_n  in  1  asynchronous active-low reset
dma_rqst  in  1  device block request (level)
dma_rd_wr  in  1  1 = memory->device (read), 0 = device->memory (write)
dma_start_address  in  16  first byte address; bit 0 ignored
dma_num_words  in  16  number of words to move
dev_ack  in  1  device ready for the next word
dev_out  in  16  write data from the device
dev_in  out  16  read data to the device (registered)
dma_ack  out  1  one-cycle pulse per completed word
dma_end_flag  out  1  transfer finished (level)
dma_error_flag  out  1  transfer failed (level)
dma_addr  out  15  memory word address
dma_din  out  16  memory write data
dma_en  out  1  memory access request
dma_we  out  2  byte write enables
dma_priority  out  1  bus priority
dma_dout  in  16  memory read data
dma_ready  in  1  memory access complete
dma_resp  in  1  memory error response (valid with dma_ready)

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset: state = IDLE. dev_in, dma_ack, dma_end_flag, dma_error_flag, dma_en, dma_we, dma_addr and dma_din are all 0. Address, count and timeout registers are 0.
- IDLE: when dma_rqst = 1, latch addr = {dma_start_address[15:1], 0}, cnt = dma_num_words and dir = dma_rd_wr.
  - If dma_num_words = 0, go to DONE.
  - Otherwise go to WAIT_DEV.
  - Inputs are sampled only in IDLE; later changes are ignored.
- WAIT_DEV: if dma_rqst = 0, abort to IDLE with no flags. Otherwise, when dev_ack = 1, go to ACCESS and clear the timeout counter.
- ACCESS:
  - dma_en = 1 and dma_addr = addr[15:1].
  - dma_we = 2'b00 for a read, 2'b11 for a write.
  - dma_din = dev_out, passed through combinationally while in ACCESS; 0 otherwise.
  - Hold until dma_ready = 1; dma_en deasserts in the cycle after dma_ready.
  - If dma_ready = 1 and dma_resp = 1: go to ERR.
  - If dma_ready = 1 and dma_resp = 0:
    - For a read, dev_in <= dma_dout.
    - addr <= addr + 2, wrapping modulo 2^16 (0xFFFE -> 0x0000) with no error.
    - cnt <= cnt - 1.
    - If dma_rqst = 0, go to IDLE (the access always completes; no dma_ack is issued).
    - Otherwise go to ACK.
  - Timeout: the counter increments on every cycle in ACCESS without dma_ready. On reaching TIMEOUT_CYCLES, go to ERR and drop dma_en.
- ACK: dma_ack = 1 for exactly one cycle, then go to GAP.
- GAP: one cycle with dev_ack ignored, giving a non-atomic device time to drop dev_ack.
  - If cnt = 0, go to DONE.
  - If dma_rqst = 0, go to IDLE.
  - Otherwise go to WAIT_DEV.
- DONE: dma_end_flag = 1 until dma_rqst = 0, then go to IDLE and clear the flag.
- ERR: dma_error_flag = 1 and dma_end_flag = 1 until dma_rqst = 0, then go to IDLE and clear both. dev_in keeps its last good value.
- Latency, zero-wait memory with dev_ack held high:
  - Request sampled at cycle 0, WAIT_DEV at cycle 1, dma_en at cycle 2, dma_ack at cycle 3.
  - 4 cycles per word thereafter (WAIT_DEV, ACCESS, ACK, GAP).
- dma_priority = DMA_PRIO at all times, including during reset.
- Reset mid-transfer: immediate return to IDLE; all outputs go to their reset values asynchronously.

Test Plan:
- Read 3 words from 0x0200 (memory holds 0x1111/0x2222/0x3333, dev_ack = 1, zero wait) -> dma_addr = 0x100, 0x101, 0x102 in turn; dev_in holds each word when its dma_ack pulses; dma_end_flag rises one cycle after the third GAP; it clears one cycle after dma_rqst falls.
- Write 2 words to 0x0301 with dev_out = 0xABCD then 0x1234, dev_ack pulsed per word -> dma_we = 11 at word addresses 0x180 and 0x181 with the matching dma_din; 2 dma_ack pulses; dma_end_flag = 1.
- dma_num_words = 0 -> dma_en never asserts; dma_end_flag = 1 within 2 cycles of the request.
- Second access answered with dma_ready = 1 and dma_resp = 1 -> exactly 1 dma_ack pulse; dma_error_flag = 1 and dma_end_flag = 1; dev_in keeps word 1.
- TIMEOUT_CYCLES = 4 with dma_ready held low -> dma_en high for 4 cycles, then dma_error_flag = 1.
- dma_rqst dropped while in WAIT_DEV at word 2 of 5, then reset_n pulsed low during a new ACCESS -> first case returns to IDLE with no flags; second case has dma_en = 0 immediately and all outputs at their reset values.
